// File: rtl/pkg_papp_tx.sv
// rtl/pkg_papp_tx.sv - APP channel responder: drains PKT_LEN words from pabuf into a HEAD/LEN/payload/SUM byte packet
// Stream outputs are registered and held while tx_vld is high and tx_rdy is low.
module pkg_papp_tx #(
  parameter logic [7:0] HEAD    = 8'hA5,
  parameter int         PKT_LEN = 32
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       fire_papp,
  output logic       done_papp,
  output logic       busy,
  output logic       pabuf_rd,
  input  logic [7:0] pabuf_q,
  input  logic       pabuf_empty,
  output logic [7:0] tx_data,
  output logic       tx_vld,
  input  logic       tx_rdy
);

  typedef enum logic [2:0] {
    S_IDLE, S_HEAD, S_LEN, S_RD, S_WAIT, S_DATA, S_SUM, S_DONE
  } state_t;

  localparam logic [7:0] LEN_B  = 8'(PKT_LEN);
  localparam logic [7:0] LAST_W = 8'(PKT_LEN - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_vld_q, tx_vld_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       xfer;

  assign xfer = tx_vld_q & tx_rdy;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    tx_data_d = tx_data_q;
    tx_vld_d  = tx_vld_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fire_papp) begin
          state_d   = S_HEAD;
          sum_d     = 8'h00;
          cnt_d     = 8'h00;
          tx_vld_d  = 1'b1;
          tx_data_d = HEAD;
        end
      end
      S_HEAD: begin
        if (xfer) begin
          state_d   = S_LEN;
          tx_data_d = LEN_B;
        end
      end
      S_LEN: begin
        if (xfer) begin
          state_d  = S_RD;
          tx_vld_d = 1'b0;
        end
      end
      S_RD: begin
        if (!pabuf_empty) state_d = S_WAIT;
      end
      S_WAIT: begin
        state_d   = S_DATA;
        tx_data_d = pabuf_q;
        tx_vld_d  = 1'b1;
      end
      S_DATA: begin
        if (xfer) begin
          sum_d = sum_q + tx_data_q;
          cnt_d = cnt_q + 8'd1;
          // The SUM byte is loaded straight from the updated running sum.
          if (cnt_q == LAST_W) begin
            state_d   = S_SUM;
            tx_data_d = sum_q + tx_data_q;
          end else begin
            state_d  = S_RD;
            tx_vld_d = 1'b0;
          end
        end
      end
      S_SUM: begin
        if (xfer) begin
          state_d  = S_DONE;
          tx_vld_d = 1'b0;
          done_d   = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'h00;
      sum_q     <= 8'h00;
      tx_data_q <= 8'h00;
      tx_vld_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // Read strobe is gated by the live empty flag so it can never fire on an empty buffer.
  assign pabuf_rd  = (state_q == S_RD) & ~pabuf_empty;
  assign tx_data   = tx_data_q;
  assign tx_vld    = tx_vld_q;
  assign done_papp = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pkg_papp_tx.sv
// tb/tb_pkg_papp_tx.sv - scoreboard bench for pkg_papp_tx with a queue-backed packet buffer model
module tb_pkg_papp_tx;
  localparam int N = 4;

  logic       clk_sys = 1'b0;
  logic       rst = 1'b1;
  logic       fire_papp = 1'b0;
  logic       tx_rdy = 1'b1;
  logic       pabuf_empty = 1'b1;
  logic [7:0] pabuf_q = 8'h00;
  logic       done_papp, busy, pabuf_rd, tx_vld;
  logic [7:0] tx_data;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int rdy_mode = 0;
  int phase = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pbuf[$];
  logic       pend_v = 1'b0;
  logic [7:0] pend_d = 8'h00;

  pkg_papp_tx #(.HEAD(8'hA5), .PKT_LEN(N)) dut (
    .clk_sys(clk_sys), .rst(rst), .fire_papp(fire_papp), .done_papp(done_papp),
    .busy(busy), .pabuf_rd(pabuf_rd), .pabuf_q(pabuf_q), .pabuf_empty(pabuf_empty),
    .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy)
  );

  always #5 clk_sys = ~clk_sys;

  // Buffer model: data appears one cycle after the read strobe.
  always @(posedge clk_sys) begin
    if (pabuf_rd && pbuf.size() > 0) pabuf_q <= pbuf.pop_front();
    pabuf_empty <= (pbuf.size() == 0);
  end

  initial begin
    forever begin
      @(posedge clk_sys);
      #1;
      case (rdy_mode)
        1: begin tx_rdy = (phase == 0); phase = (phase + 1) % 3; end
        2: tx_rdy = 1'($urandom_range(0, 1));
        default: tx_rdy = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every stream transfer.
  always @(negedge clk_sys) begin
    if (rst) begin
      pend_v = 1'b0;
      rd_cnt = 0;
    end else begin
      if (pend_v) begin
        tests++;
        if (!(tx_vld && tx_data == pend_d)) begin
          fails++;
          $display("FAIL stall_hold: vld=%0b data=%02h, required vld=1 data=%02h", tx_vld, tx_data, pend_d);
        end
      end
      if (pabuf_rd) begin
        rd_cnt++;
        tests++;
        if (pabuf_empty || tx_vld) begin
          fails++;
          $display("FAIL rd_gate: rd with empty=%0b vld=%0b, required both 0", pabuf_empty, tx_vld);
        end
      end
      if (tx_vld && tx_rdy) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL stream: unexpected byte %02h, required no transfer", tx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (tx_data != e) begin
            fails++;
            $display("FAIL stream: got %02h, required %02h", tx_data, e);
          end
        end
      end
      pend_v = tx_vld && !tx_rdy;
      pend_d = tx_data;
      if (done_papp) begin
        done_cnt++;
        tests++;
        if (exp_q.size() != 0 || rd_cnt != N || !busy) begin
          fails++;
          $display("FAIL done: left=%0d rds=%0d busy=%0b, required left=0 rds=%0d busy=1",
                   exp_q.size(), rd_cnt, busy, N);
        end
        rd_cnt = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic start_pkt(input logic [7:0] b0, b1, b2, b3, input int nload);
    logic [7:0] pl[4];
    int s;
    pl = '{b0, b1, b2, b3};
    s = 0;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(N));
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(pl[i]);
      s = s + int'(pl[i]);
    end
    exp_q.push_back(8'(s % 256));
    for (int i = 0; i < nload; i++) pbuf.push_back(pl[i]);
    fire_papp = 1'b1;
    tick(1);
    fire_papp = 1'b0;
  endtask

  task automatic start_rand();
    start_pkt(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4);
  endtask

  task automatic wait_done(input int target, input string nm);
    int t;
    t = 0;
    while (done_cnt < target && t < 1000) begin
      tick(1);
      t++;
    end
    tests++;
    if (done_cnt != target) begin
      fails++;
      $display("FAIL %s: done count %0d, required %0d", nm, done_cnt, target);
    end
  endtask

  task automatic check_idle(input string nm, input int target);
    tests++;
    if (done_cnt != target || busy || tx_vld || exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: done=%0d busy=%0b vld=%0b left=%0d, required done=%0d busy=0 vld=0 left=0",
               nm, done_cnt, busy, tx_vld, exp_q.size(), target);
    end
  endtask

  initial begin
    int t;
    int gap_bad;
    int dc;
    tick(2);
    tests++;
    if (done_papp || busy || pabuf_rd || tx_vld || tx_data != 8'h00) begin
      fails++;
      $display("FAIL reset: done=%0b busy=%0b rd=%0b vld=%0b data=%02h, required all 0",
               done_papp, busy, pabuf_rd, tx_vld, tx_data);
    end
    rst = 1'b0;
    tick(2);

    rdy_mode = 0;
    start_pkt(8'h01, 8'h02, 8'h03, 8'h04, 4);
    wait_done(1, "basic");
    rdy_mode = 1;
    start_pkt(8'h01, 8'h02, 8'h03, 8'h04, 4);
    wait_done(2, "backpressure");
    rdy_mode = 0;
    start_pkt(8'hFF, 8'hFF, 8'hFF, 8'hFF, 4);
    wait_done(3, "sum_wrap");

    start_pkt(8'h10, 8'h20, 8'h30, 8'h40, 2);
    tick(12);
    gap_bad = 0;
    for (int i = 0; i < 15; i++) begin
      if (tx_vld) gap_bad++;
      tick(1);
    end
    tests++;
    if (gap_bad != 0) begin
      fails++;
      $display("FAIL empty_gap: tx_vld high %0d cycles, required 0", gap_bad);
    end
    pbuf.push_back(8'h30);
    pbuf.push_back(8'h40);
    wait_done(4, "empty_gap_done");

    rdy_mode = 2;
    start_rand();
    tick(6);
    fire_papp = 1'b1;
    tick(1);
    fire_papp = 1'b0;
    wait_done(5, "fire_busy");
    tick(10);
    check_idle("fire_busy_ignored", 5);
    start_rand();
    wait_done(6, "after_ignore");

    start_rand();
    t = 0;
    while (!done_papp && t < 1000) begin
      tick(1);
      t++;
    end
    fire_papp = 1'b1;
    tick(1);
    fire_papp = 1'b0;
    tick(10);
    check_idle("fire_in_done", 7);

    rdy_mode = 0;
    start_rand();
    t = 0;
    while (!(tx_vld && exp_q.size() == 4) && t < 200) begin
      tick(1);
      t++;
    end
    dc = done_cnt;
    rst = 1'b1;
    #1;
    tests++;
    if (t >= 200 || done_papp || busy || pabuf_rd || tx_vld || tx_data != 8'h00) begin
      fails++;
      $display("FAIL async_reset: t=%0d done=%0b busy=%0b rd=%0b vld=%0b data=%02h, required all 0",
               t, done_papp, busy, pabuf_rd, tx_vld, tx_data);
    end
    exp_q.delete();
    pbuf.delete();
    tick(3);
    rst = 1'b0;
    tick(5);
    check_idle("reset_no_done", dc);
    start_rand();
    wait_done(dc + 1, "after_reset");

    rdy_mode = 2;
    for (int i = 0; i < 6; i++) begin
      start_rand();
      wait_done(dc + 2 + i, "random");
    end
    tick(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
